fact_controller: RTL and testbench
==================================

Name: fact_controller

Overview:
- Control FSM that sequences the 8-bit factorial datapath: mux, 4x8 register file, ALU, output register.
- Drives every datapath control input and consumes the datapath `compare` flag (ALU result == 1).
- Loads N from the datapath `Data_i` port, then iterates decrement/multiply until the counter reaches 1.
- Latches N! (mod 256) into the datapath output register and pulses `done`.

Parameters:
- OP_PASS, 3'b000, Sel_alu code: result = A
- OP_INC, 3'b001, Sel_alu code: result = A + 1
- OP_DEC, 3'b010, Sel_alu code: result = A - 1
- OP_MUL, 3'b011, Sel_alu code: result = A * B (low 8 bits)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request a computation; sampled only in IDLE
- compare  in  1  datapath flag: ALU output == 1
- IE  out  1  1 = register file writes Data_i, 0 = writes ALU result
- we  out  1  register file write enable
- wa  out  2  register file write address
- rea  out  1  read enable, port A
- raa  out  2  read address, port A
- reb  out  1  read enable, port B
- rab  out  2  read address, port B
- Sel_alu  out  3  ALU operation
- OE  out  1  load enable of the datapath output register
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse; Out is valid when done is high

Behaviour:
- Register map: R0 = counter N, R1 = accumulator.
- Outputs are a pure decode of the state register (Moore); none depends combinationally on compare or start.
- Reset: state = IDLE; all outputs 0 (Sel_alu = OP_PASS, addresses 0).
- Any control output not listed for a state is 0.

State sequence:
- IDLE: all controls 0. Go to LOAD if start, else stay.
- LOAD: IE=1, we=1, wa=0 (R0 <= Data_i). Data_i must be valid in this cycle. Go to TEST0.
- TEST0: rea=1, raa=0, Sel_alu=OP_INC, no write. Go to ZERO_OUT if compare (N==0), else TEST1.
- ZERO_OUT: rea=1, raa=0, Sel_alu=OP_INC, OE=1 (Out <= 1). Go to DONE.
- TEST1: rea=1, raa=0, Sel_alu=OP_PASS. Go to ONE_OUT if compare (N==1), else INIT.
- ONE_OUT: rea=1, raa=0, Sel_alu=OP_PASS, OE=1 (Out <= 1). Go to DONE.
- INIT: rea=1, raa=0, Sel_alu=OP_PASS, we=1, wa=1 (R1 <= R0). Go to DEC.
- DEC: rea=1, raa=0, Sel_alu=OP_DEC, we=1, wa=0 (R0 <= R0-1). Go to OUTPUT if compare (new R0==1), else MUL.
- MUL: rea=1, raa=1, reb=1, rab=0, Sel_alu=OP_MUL, we=1, wa=1 (R1 <= R1*R0). Go to DEC.
- OUTPUT: rea=1, raa=1, Sel_alu=OP_PASS, OE=1 (Out <= R1). Go to DONE.
- DONE: done=1. Go to IDLE.

Timing (cycle k = k-th rising edge after the edge that samples start):
- done is high after edge 2N+3 for N>=2.
- N=0: done after edge 4. N=1: done after edge 5.

Boundaries:
- start while busy is ignored. start held high across DONE begins a new run from IDLE on the next cycle.
- Results above 255 wrap mod 256 in the datapath; the controller does not detect this.
- rst mid-run returns immediately to IDLE with all outputs 0; Out contents are not guaranteed.

Optional Feature:
- Macro FACT_CYCLE_CNT_EN.
- Defined:
  - Adds output `cycles` [7:0]: clears on entry to LOAD, increments every cycle while busy, holds in IDLE.
  - Saturates at 255. Reset value 0.
  - When done is high, it reads the cycle count of the run (e.g. 13 for N=5).
- Undefined: port absent; no counter logic.

Test Plan:
- Reset mid-run: start with N=5, assert rst during the 3rd MUL -> all outputs 0 immediately; state IDLE; done never pulses.
- N=5: pulse start, present Data_i=5 in LOAD -> 4 DEC and 3 MUL cycles; OE high once; Out=120; done high after edge 13.
- N=0 -> ZERO_OUT path, Out=1, done after edge 4. N=1 -> ONE_OUT path, Out=1, done after edge 5; no MUL cycle in either case.
- N=2 -> INIT, DEC, OUTPUT; Out=2; done after edge 7. N=6 -> Out=208 (720 mod 256); done after edge 15.
- start pulsed during busy, and start held high through DONE -> mid-run pulse ignored; held start triggers a second run; the two done pulses are 2N+4 cycles apart (N>=2).
- FACT_CYCLE_CNT_EN defined, N=4 -> cycles=11 when done is high; value holds in IDLE.

Source files
------------

// File: rtl/fact_controller_if.sv
// fact_controller_if: control bundle between the factorial controller and
// the 8-bit factorial datapath / host.
//   start    host -> controller, run request (sampled only in IDLE)
//   compare  datapath -> controller, ALU output == 1
//   IE, we, wa              register file write mux / enable / address
//   rea, raa, reb, rab      register file read enables / addresses
//   Sel_alu                 ALU operation
//   OE                      output register load enable
//   busy, done              run status; Out is valid while done is high
//   cycles   (FACT_CYCLE_CNT_EN only) busy-cycle count of the last run
// Modports: master = controller side, slave = datapath/host side.
interface fact_controller_if;
   logic       start;
   logic       compare;
   logic       IE;
   logic       we;
   logic [1:0] wa;
   logic       rea;
   logic [1:0] raa;
   logic       reb;
   logic [1:0] rab;
   logic [2:0] Sel_alu;
   logic       OE;
   logic       busy;
   logic       done;
`ifdef FACT_CYCLE_CNT_EN
   logic [7:0] cycles;
`endif

   modport master (
      input  start, compare,
      output IE, we, wa, rea, raa, reb, rab, Sel_alu, OE, busy, done
`ifdef FACT_CYCLE_CNT_EN
      , output cycles
`endif
   );

   modport slave (
      output start, compare,
      input  IE, we, wa, rea, raa, reb, rab, Sel_alu, OE, busy, done
`ifdef FACT_CYCLE_CNT_EN
      , input cycles
`endif
   );
endinterface

// File: rtl/fact_controller.sv
// fact_controller: Moore control FSM sequencing the 8-bit factorial
// datapath (mux, 4x8 register file, ALU, output register).
// R0 holds the counter N, R1 the accumulator. Computes N! mod 256.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   ctl  fact_controller_if.master (start/compare in, datapath controls,
//        busy/done out)
// Optional feature macro FACT_CYCLE_CNT_EN: adds ctl.cycles, the number of
// busy cycles of the run (saturating at 255, held while idle).
module fact_controller #(
   parameter logic [2:0] OP_PASS = 3'b000,
   parameter logic [2:0] OP_INC  = 3'b001,
   parameter logic [2:0] OP_DEC  = 3'b010,
   parameter logic [2:0] OP_MUL  = 3'b011
) (
   input logic               clk,
   input logic               rst,
   fact_controller_if.master ctl
);

   typedef enum logic [3:0] {
      S_IDLE,
      S_LOAD,
      S_TEST0,
      S_ZERO_OUT,
      S_TEST1,
      S_ONE_OUT,
      S_INIT,
      S_DEC,
      S_MUL,
      S_OUTPUT,
      S_DONE
   } state_t;

   state_t state;
   state_t state_nxt;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:     if (ctl.start) state_nxt = S_LOAD;
         S_LOAD:     state_nxt = S_TEST0;
         S_TEST0:    state_nxt = ctl.compare ? S_ZERO_OUT : S_TEST1;
         S_ZERO_OUT: state_nxt = S_DONE;
         S_TEST1:    state_nxt = ctl.compare ? S_ONE_OUT : S_INIT;
         S_ONE_OUT:  state_nxt = S_DONE;
         S_INIT:     state_nxt = S_DEC;
         // compare reflects the decremented value being written to R0
         S_DEC:      state_nxt = ctl.compare ? S_OUTPUT : S_MUL;
         S_MUL:      state_nxt = S_DEC;
         S_OUTPUT:   state_nxt = S_DONE;
         S_DONE:     state_nxt = S_IDLE;
         default:    state_nxt = S_IDLE;
      endcase
   end

   // Output decode (pure function of state)
   always_comb begin
      ctl.IE      = 1'b0;
      ctl.we      = 1'b0;
      ctl.wa      = '0;
      ctl.rea     = 1'b0;
      ctl.raa     = '0;
      ctl.reb     = 1'b0;
      ctl.rab     = '0;
      ctl.Sel_alu = OP_PASS;
      ctl.OE      = 1'b0;
      ctl.busy    = (state != S_IDLE);
      ctl.done    = 1'b0;
      case (state)
         S_LOAD: begin
            ctl.IE = 1'b1;
            ctl.we = 1'b1;
         end
         S_TEST0: begin
            ctl.rea     = 1'b1;
            ctl.Sel_alu = OP_INC;
         end
         S_ZERO_OUT: begin
            ctl.rea     = 1'b1;
            ctl.Sel_alu = OP_INC;
            ctl.OE      = 1'b1;
         end
         S_TEST1: begin
            ctl.rea = 1'b1;
         end
         S_ONE_OUT: begin
            ctl.rea = 1'b1;
            ctl.OE  = 1'b1;
         end
         S_INIT: begin
            ctl.rea = 1'b1;
            ctl.we  = 1'b1;
            ctl.wa  = 2'd1;
         end
         S_DEC: begin
            ctl.rea     = 1'b1;
            ctl.Sel_alu = OP_DEC;
            ctl.we      = 1'b1;
         end
         S_MUL: begin
            ctl.rea     = 1'b1;
            ctl.raa     = 2'd1;
            ctl.reb     = 1'b1;
            ctl.Sel_alu = OP_MUL;
            ctl.we      = 1'b1;
            ctl.wa      = 2'd1;
         end
         S_OUTPUT: begin
            ctl.rea = 1'b1;
            ctl.raa = 2'd1;
            ctl.OE  = 1'b1;
         end
         S_DONE: begin
            ctl.done = 1'b1;
         end
         default: ;
      endcase
   end

`ifdef FACT_CYCLE_CNT_EN
   logic [7:0] cycle_cnt;

   // Restarting at 1 counts the LOAD cycle itself; no increment out of DONE,
   // so the value seen with done is the run length and is held in IDLE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cycle_cnt <= '0;
      else if (state == S_IDLE && ctl.start)
         cycle_cnt <= 8'd1;
      else if (state != S_IDLE && state != S_DONE && cycle_cnt != '1)
         cycle_cnt <= cycle_cnt + 8'd1;
   end

   assign ctl.cycles = cycle_cnt;
`endif

endmodule

// File: tb/tb_fact_controller.sv
// tb_fact_controller: randomized self-checking bench for fact_controller.
// A behavioural datapath closes the loop; expectations (N! mod 256,
// run length, DEC/MUL/OE cycle counts) come from plain arithmetic.
module tb_fact_controller;

   logic clk = 1'b0;
   logic rst;
   int   n_vec = 0;
   int   n_err = 0;

   fact_controller_if ctl();

   always #5 clk = ~clk;

   fact_controller dut (
      .clk (clk),
      .rst (rst),
      .ctl (ctl)
   );

   // Behavioural datapath: register file, ALU, output register
   logic [7:0] rf [4];
   logic [7:0] out_reg;
   logic [7:0] n_cur;
   logic [7:0] junk = 8'hA5;
   logic [7:0] data_i;
   logic [7:0] alu_a;
   logic [7:0] alu_b;
   logic [7:0] alu_y;

   always_comb begin
      alu_a = ctl.rea ? rf[ctl.raa] : 8'd0;
      alu_b = ctl.reb ? rf[ctl.rab] : 8'd0;
      case (ctl.Sel_alu)
         3'b001:  alu_y = alu_a + 8'd1;
         3'b010:  alu_y = alu_a - 8'd1;
         3'b011:  alu_y = alu_a * alu_b;
         default: alu_y = alu_a;
      endcase
   end

   // Data_i only carries N in the load cycle; anything else is noise
   assign data_i      = ctl.IE ? n_cur : junk;
   assign ctl.compare = (alu_y == 8'd1);

   always @(posedge clk) begin
      if (ctl.we) rf[ctl.wa] <= ctl.IE ? data_i : alu_y;
      if (ctl.OE) out_reg <= alu_y;
   end

   // Activity monitor (cumulative totals; tests take differences)
   int         mul_tot  = 0;
   int         dec_tot  = 0;
   int         oe_tot   = 0;
   int         done_tot = 0;
   logic [7:0] out_at_done = 8'd0;

   always @(negedge clk) begin
      junk <= 8'($urandom);
      if (ctl.we && ctl.Sel_alu == 3'b011) mul_tot <= mul_tot + 1;
      if (ctl.we && ctl.Sel_alu == 3'b010) dec_tot <= dec_tot + 1;
      if (ctl.OE) oe_tot <= oe_tot + 1;
      if (ctl.done) begin
         done_tot    <= done_tot + 1;
         out_at_done <= out_reg;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Reference model
   function automatic int fact_mod(input int n);
      int r = 1;
      for (int i = 2; i <= n; i++) r = (r * i) % 256;
      return r;
   endfunction

   function automatic int exp_lat(input int n);
      if (n == 0) return 4;
      if (n == 1) return 5;
      return 2 * n + 3;
   endfunction

   function automatic int exp_mul(input int n);
      return (n >= 2) ? n - 2 : 0;
   endfunction

   function automatic int exp_dec(input int n);
      return (n >= 2) ? n - 1 : 0;
   endfunction

   function automatic logic [31:0] all_outs();
      return {17'd0, ctl.IE, ctl.we, ctl.wa, ctl.rea, ctl.raa, ctl.reb,
              ctl.rab, ctl.Sel_alu, ctl.OE, ctl.busy, ctl.done};
   endfunction

   task automatic run_fact(input int n, input bit pulse_mid, input bit hold);
      int edges;
      int gap;
      int m0;
      int d0;
      int o0;
      int dn0;
      n_cur = 8'(n);
      m0 = mul_tot; d0 = dec_tot; o0 = oe_tot; dn0 = done_tot;
      ctl.start = 1'b1;
      @(posedge clk); #1;
      edges = 1;
      ctl.start = hold;
      while (!ctl.done && edges < 200) begin
         @(posedge clk); #1;
         edges++;
         if (!hold) ctl.start = pulse_mid && (edges == 5);
      end
      check("latency", edges, exp_lat(n));
`ifdef FACT_CYCLE_CNT_EN
      check("cycles_at_done", ctl.cycles, exp_lat(n));
`endif
      @(negedge clk); #1;
      check("result", out_at_done, fact_mod(n));
      check("mul_cycles", mul_tot - m0, exp_mul(n));
      check("dec_cycles", dec_tot - d0, exp_dec(n));
      check("oe_cycles", oe_tot - o0, 1);
      check("done_pulses", done_tot - dn0, 1);
      if (hold) begin
         gap = 0;
         while (gap < 200) begin
            @(posedge clk); #1;
            gap++;
            if (ctl.IE) ctl.start = 1'b0;
            if (ctl.done) break;
         end
         check("held_start_gap", gap, 2 * n + 4);
         @(negedge clk); #1;
         check("second_result", out_at_done, fact_mod(n));
         check("second_done_pulses", done_tot - dn0, 2);
      end
      repeat (3) @(posedge clk);
      #1;
      check("idle_outputs", all_outs(), 0);
`ifdef FACT_CYCLE_CNT_EN
      check("cycles_hold_idle", ctl.cycles, exp_lat(n));
`endif
   endtask

   task automatic reset_mid_run();
      int nm = 0;
      int k = 0;
      int dn0;
      n_cur = 8'd5;
      dn0 = done_tot;
      ctl.start = 1'b1;
      @(posedge clk); #1;
      ctl.start = 1'b0;
      while (nm < 3 && k < 100) begin
         @(posedge clk); #1;
         k++;
         if (ctl.we && ctl.Sel_alu == 3'b011) nm++;
      end
      check("rst_reached_mul3", nm, 3);
      rst = 1'b1;
      #1;
      check("rst_async_outputs", all_outs(), 0);
      @(posedge clk); #1;
      check("rst_held_outputs", all_outs(), 0);
`ifdef FACT_CYCLE_CNT_EN
      check("rst_cycles", ctl.cycles, 0);
`endif
      rst = 1'b0;
      repeat (30) @(posedge clk);
      #1;
      check("rst_no_done", done_tot - dn0, 0);
      check("rst_idle_outputs", all_outs(), 0);
   endtask

   initial begin
      int n;
      rst = 1'b1;
      ctl.start = 1'b0;
      n_cur = 8'd0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_outputs", all_outs(), 0);
`ifdef FACT_CYCLE_CNT_EN
      check("reset_cycles", ctl.cycles, 0);
`endif
      rst = 1'b0;
      @(posedge clk); #1;
      check("idle_after_reset", all_outs(), 0);

      run_fact(0, 1'b0, 1'b0);
      run_fact(1, 1'b0, 1'b0);
      run_fact(2, 1'b0, 1'b0);
      run_fact(5, 1'b0, 1'b0);
      run_fact(6, 1'b0, 1'b0);
      run_fact(4, 1'b0, 1'b0);
      run_fact(5, 1'b1, 1'b0);
      run_fact(4, 1'b0, 1'b1);
      reset_mid_run();
      run_fact(5, 1'b0, 1'b0);

      for (int t = 0; t < 12; t++) begin
         n = int'($urandom_range(0, 12));
         run_fact(n, (n >= 3) && ($urandom_range(0, 1) == 1),
                  (n >= 2) && ($urandom_range(0, 2) == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
